// File: rtl/sprite_animator_if.sv
// Scan, control, bitmap-write and pixel-output signals of the sprite animator.
// The master side drives the scan and write inputs; the slave side is the renderer.
interface sprite_animator_if #(
   parameter int ADDR_W = 9
);
   logic [9:0]        x;
   logic [8:0]        y;
   logic [9:0]        x0;
   logic [8:0]        y0;
   logic              chosen;
   logic              mirror;
   logic              pause;
   logic              frame_start;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [1:0]        wr_data;
   logic [7:0]        r;
   logic [7:0]        g;
   logic [7:0]        b;
   logic              in_sprite;

   modport master (
      output x, y, x0, y0, chosen, mirror, pause, frame_start,
      output wr_en, wr_addr, wr_data,
      input  r, g, b, in_sprite
   );

   modport slave (
      input  x, y, x0, y0, chosen, mirror, pause, frame_start,
      input  wr_en, wr_addr, wr_data,
      output r, g, b, in_sprite
   );
endinterface

// File: rtl/sprite_animator.sv
// Animated, palette-indexed sprite renderer: box test, bitmap lookup and palette
// mapping in a 3-stage pipeline, with vsync-driven frame cycling.
module sprite_animator #(
   parameter int GRID_LOG2   = 4,
   parameter int SCALE_LOG2  = 3,
   parameter int FRAME_LOG2  = 1,
   parameter int FRAME_TICKS = 15
) (
   input  logic clk,
   input  logic rst,
   sprite_animator_if.slave bus
);
   localparam int GRID   = 1 << GRID_LOG2;
   localparam int SIZE   = GRID << SCALE_LOG2;
   localparam int ADDR_W = FRAME_LOG2 + 2 * GRID_LOG2;
   localparam int FW     = (FRAME_LOG2 > 0) ? FRAME_LOG2 : 1;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam logic [23:0] BG = 24'hFFFFFF;

   function automatic logic [23:0] palette(input logic [1:0] idx);
      case (idx)
         2'd1:    palette = 24'h0F0F0F;
         2'd2:    palette = 24'hFFFF00;
         2'd3:    palette = 24'hFF0000;
         default: palette = BG;
      endcase
   endfunction

   logic [7:0]          tick;
   logic [FW-1:0]       frame;
   logic [10:0]         xw, x0w, yw, y0w, xd, yd, dx, dy;
   logic                in_box;
   logic [GRID_LOG2-1:0] col, row;
   logic [FW+2*GRID_LOG2-1:0] addr_full;

   logic                vld_p0, vld_p1;
   logic [ADDR_W-1:0]   addr_p0;
   logic [1:0]          idx_p1;
   logic [23:0]         rgb_p2;
   logic                opq_p2;
   logic [1:0]          mem [DEPTH];

   // 11-bit operands keep x0+SIZE from wrapping at the right screen edge
   always_comb begin
      xw     = {1'b0, bus.x};
      x0w    = {1'b0, bus.x0};
      yw     = {2'b00, bus.y};
      y0w    = {2'b00, bus.y0};
      xd     = xw - x0w;
      yd     = yw - y0w;
      in_box = (xw > x0w) && (xd <= 11'(SIZE)) && (yw > y0w) && (yd <= 11'(SIZE));
      dx     = xd - 11'd1;
      dy     = yd - 11'd1;
      col    = GRID_LOG2'(dx >> SCALE_LOG2);
      row    = GRID_LOG2'(dy >> SCALE_LOG2);
      if (bus.mirror)
         col = ~col;
      addr_full = {frame, row, col};
   end

   // Deselecting restarts the animation from frame 0
   always_ff @(posedge clk) begin
      if (rst || !bus.chosen) begin
         tick  <= '0;
         frame <= '0;
      end else if (bus.frame_start && !bus.pause) begin
         if (tick == 8'(FRAME_TICKS - 1)) begin
            tick  <= '0;
            frame <= (FRAME_LOG2 == 0) ? '0 : frame + 1'b1;
         end else begin
            tick <= tick + 8'd1;
         end
      end
   end

   // Stage 1: box/select qualification and bitmap address
   always_ff @(posedge clk) begin
      if (rst)
         vld_p0 <= 1'b0;
      else
         vld_p0 <= in_box && bus.chosen;
   end

   always_ff @(posedge clk)
      addr_p0 <= ADDR_W'(addr_full);

   // Stage 2: bitmap read (read-before-write on an address collision)
   always_ff @(posedge clk) begin
      if (bus.wr_en)
         mem[bus.wr_addr] <= bus.wr_data;
      idx_p1 <= mem[addr_p0];
   end

   always_ff @(posedge clk) begin
      if (rst)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= vld_p0;
   end

   // Stage 3: palette lookup into the output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_p2 <= BG;
         opq_p2 <= 1'b0;
      end else if (vld_p1 && (idx_p1 != 2'd0)) begin
         rgb_p2 <= palette(idx_p1);
         opq_p2 <= 1'b1;
      end else begin
         rgb_p2 <= BG;
         opq_p2 <= 1'b0;
      end
   end

   assign bus.r         = rgb_p2[23:16];
   assign bus.g         = rgb_p2[15:8];
   assign bus.b         = rgb_p2[7:0];
   assign bus.in_sprite = opq_p2;
endmodule
